// File: rtl/ula_sequenciador.sv
// Sequencer in front of the 8-bit add/subtract ULA: loads A, B and op from a byte
// stream, captures the ULA sum with Z/N/C/V flags, and flags any disagreement with a local sum.
module ula_sequenciador #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_flags,
  output logic              erro,
  output logic              busy,
  output logic [DATA_W-1:0] ula_a,
  output logic [DATA_W-1:0] ula_b,
  output logic              ula_op,
  input  logic [DATA_W-1:0] ula_s
);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] reg_a_q, reg_a_d;
  logic [DATA_W-1:0] reg_b_q, reg_b_d;
  logic              reg_op_q, reg_op_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [3:0]        out_flags_q, out_flags_d;
  logic              erro_q, erro_d;

  logic [DATA_W-1:0] bt;
  logic [DATA_W:0]   ref_sum;
  logic              load_state;
  logic              xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD_A;
      reg_a_q      <= '0;
      reg_b_q      <= '0;
      reg_op_q     <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      erro_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      reg_a_q      <= reg_a_d;
      reg_b_q      <= reg_b_d;
      reg_op_q     <= reg_op_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
      erro_q       <= erro_d;
    end
  end

  // Independent reference sum used both for C/V and for checking the external ULA.
  always_comb begin
    bt      = reg_b_q ^ {DATA_W{reg_op_q}};
    ref_sum = {1'b0, reg_a_q} + {1'b0, bt} + {{DATA_W{1'b0}}, reg_op_q};
  end

  always_comb begin
    load_state = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_OP);
    xfer       = in_valid && load_state;
  end

  always_comb begin
    state_d      = state_q;
    reg_a_d      = reg_a_q;
    reg_b_d      = reg_b_q;
    reg_op_d     = reg_op_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    erro_d       = erro_q;
    case (state_q)
      LOAD_A: if (xfer) begin
        reg_a_d = in_data;
        state_d = LOAD_B;
      end
      LOAD_B: if (xfer) begin
        reg_b_d = in_data;
        state_d = LOAD_OP;
      end
      LOAD_OP: if (xfer) begin
        reg_op_d = in_data[0];
        state_d  = EXEC;
      end
      EXEC: begin
        out_result_d   = ula_s;
        out_flags_d[3] = (ula_s == '0);
        out_flags_d[2] = ula_s[DATA_W-1];
        out_flags_d[1] = ref_sum[DATA_W];
        out_flags_d[0] = (reg_a_q[DATA_W-1] == bt[DATA_W-1]) &&
                         (ref_sum[DATA_W-1] != reg_a_q[DATA_W-1]);
        if (ula_s != ref_sum[DATA_W-1:0]) erro_d = 1'b1;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  assign in_ready   = load_state && !reset;
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == EXEC) || (state_q == DONE);
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign erro       = erro_q;
  assign ula_a      = reg_a_q;
  assign ula_b      = reg_b_q;
  assign ula_op     = reg_op_q;

endmodule

// File: doc/ula_sequenciador.md
# ula_sequenciador

Sequencing stage directly upstream of the 8-bit add/subtract ULA. It accepts operand A, operand B and the operation code as three successive bytes over a valid/ready input stream and drives them to the ULA from registers. It captures the ULA sum one cycle later together with Z/N/C/V flags and presents the result on a valid/ready output stream. It also cross-checks the ULA output against an internal reference sum and flags any mismatch.

## Interface
- DATA_W, 8, operand/result width; fixed at 8 to match the ULA.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_data  in  8  operand A, operand B, or opcode byte (bit 0 = op: 0 add, 1 subtract; bits 7:1 ignored).
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  8  captured ULA sum.
- out_flags  out  4  [3]=Z, [2]=N, [1]=C, [0]=V.
- erro  out  1  sticky; ULA output disagreed with the internal reference.
- busy  out  1  high in EXEC and DONE.
- ula_a  out  8  to ULA input A (registered).
- ula_b  out  8  to ULA input B (registered).
- ula_op  out  1  to ULA op/carry-in (registered).
- ula_s  in  8  ULA sum output, combinational from ula_a/ula_b/ula_op.

## Operation
- States: LOAD_A, LOAD_B, LOAD_OP, EXEC, DONE.
- A byte is transferred on a rising edge where in_valid && in_ready.
- in_ready = 1 in LOAD_A/LOAD_B/LOAD_OP and 0 in EXEC/DONE. It is decoded from the state register and is 0 while reset is high.
- LOAD_A: on transfer, reg_a <= in_data; go to LOAD_B. LOAD_B: on transfer, reg_b <= in_data; go to LOAD_OP. LOAD_OP: on transfer, reg_op <= in_data[0]; go to EXEC. With no transfer, stay.
- ula_a/ula_b/ula_op are reg_a/reg_b/reg_op directly.
- EXEC (exactly one cycle): out_result <= ula_s; compute the flags below; go to DONE.
  - bt = reg_b XOR {8{reg_op}}; ref = {1'b0,reg_a} + {1'b0,bt} + reg_op (9 bits).
  - Z = (ula_s == 0); N = ula_s[7]; C = ref[8] (for subtract, 1 = no borrow); V = (reg_a[7] == bt[7]) && (ref[7] != reg_a[7]).
  - If ula_s != ref[7:0], erro <= 1. Only reset clears erro.
- DONE: out_valid = 1. out_result/out_flags hold stable until a rising edge with out_ready = 1, then go to LOAD_A and out_valid drops.
- reg_a, reg_b and reg_op keep their values after a result is consumed until overwritten by the next load.
- Arithmetic is modulo 256; the carry out of bit 7 appears only in C.

## Timing
- Reset (synchronous, dominates every other input): state = LOAD_A; reg_a = reg_b = 0, reg_op = 0; out_result = 0, out_flags = 0, out_valid = 0, erro = 0, busy = 0. in_ready = 1 from the first cycle after reset deasserts.
- Latency: opcode accepted on edge k → EXEC during cycle k..k+1 → out_valid high from edge k+1. If out_ready is already high, the result is consumed on edge k+2 and LOAD_A is re-entered; the next operand can be accepted on edge k+3.
- Throughput: at most one operation per 5 cycles.
- in_valid while in_ready = 0: ignored. The input is not consumed and the upstream source must hold it.
- out_ready while out_valid = 0: no effect.
- Reset mid-operation (any state): partial operands are discarded and the pending result is dropped. erro is cleared.
- in_data changes without in_valid: no effect.

## Test plan
- Load 0x05, 0x03, op=0x01 → out_result = 0x02, out_flags = 4'b0010 (C=1). out_valid rises one cycle after the opcode edge.
- Load 0x03, 0x05, op=0x01 → out_result = 0xFE, out_flags = 4'b0100 (N=1, C=0, V=0).
- Load 0x7F, 0x01, op=0x00 → out_result = 0x80, out_flags = 4'b0101. Load 0xFF, 0x01, op=0x00 → out_result = 0x00, out_flags = 4'b1010.
- Hold out_ready = 0 for 5 cycles in DONE while driving in_valid = 1 → out_valid, out_result and out_flags stay stable and in_ready stays 0. Raising out_ready → one result consumed, then LOAD_A.
- Load A and B, then pulse reset for 1 cycle → state is LOAD_A and all outputs are zero. A fresh sequence 0x10, 0x20, op=0x00 → out_result = 0x30.
- Force ula_s = 0x00 for operands 0x01 + 0x01 → erro = 1 and it stays 1 across later correct operations until reset.
